// File: rtl/jtkcpu_busctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtkcpu_busctl: CPU-to-memory bus controller with wait states, access     |
// | timeout and synchronized interrupt inputs.            Revision: 1.0      |
// +--------------------------------------------------------------------------+
module jtkcpu_busctl #(
  parameter int WAIT    = 0,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  input  logic        cpu_as,
  output logic [7:0]  cpu_din,
  output logic        cpu_dtack,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_dout,
  output logic        mem_we,
  output logic        mem_cs,
  input  logic [7:0]  mem_din,
  input  logic        mem_ok,
  input  logic        nmi_pin,
  input  logic        irq_pin,
  input  logic        firq_pin,
  output logic        cpu_nmi,
  output logic        cpu_irq,
  output logic        cpu_firq,
  input  logic        nmi_ack,
  output logic        bus_err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
  localparam bit         HAS_WAIT  = (WAIT > 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        we_q, we_d;
  logic [7:0]  din_q, din_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    we_d    = we_q;
    din_d   = din_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cen && cpu_as) begin
          addr_d = cpu_addr;
          dout_d = cpu_dout;
          we_d   = cpu_we;
          tcnt_d = '0;
          if (HAS_WAIT) begin
            wcnt_d  = WAIT_INIT;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (cen) begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // mem_ok is checked first so it wins over a coincident timeout
        if (mem_ok) begin
          if (!we_q) din_d = mem_din;
          state_d = ST_DONE;
        end else if (cen) begin
          tcnt_d = tcnt_q + 8'd1;
          if (tcnt_q == TO_LAST) begin
            din_d   = 8'hFF;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (cen && !cpu_as) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      we_q    <= 1'b0;
      din_q   <= 8'hFF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

  assign mem_cs    = (state_q == ST_ACCESS);
  assign cpu_dtack = (state_q == ST_DONE);
  assign mem_addr  = addr_q;
  assign mem_dout  = dout_q;
  assign mem_we    = we_q;
  assign cpu_din   = din_q;
  assign bus_err   = err_q;

  logic [1:0] nmi_sync_q, irq_sync_q, firq_sync_q;
  logic [1:0] warm_q;
  logic       nmi_prev_q;
  logic       nmi_q;
  logic       nmi_rise;

  // Edge detection is only armed once the synchronizer holds a real pin sample,
  // so a pin already high at reset release is treated as a level, not an edge.
  assign nmi_rise = warm_q[1] & nmi_sync_q[1] & ~nmi_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_sync_q  <= '0;
      irq_sync_q  <= '0;
      firq_sync_q <= '0;
      warm_q      <= '0;
      nmi_prev_q  <= 1'b1;
      nmi_q       <= 1'b0;
    end else begin
      nmi_sync_q  <= {nmi_sync_q[0], nmi_pin};
      irq_sync_q  <= {irq_sync_q[0], irq_pin};
      firq_sync_q <= {firq_sync_q[0], firq_pin};
      warm_q      <= {warm_q[0], 1'b1};
      nmi_prev_q  <= warm_q[1] ? nmi_sync_q[1] : 1'b1;
      if (nmi_rise) begin
        nmi_q <= 1'b1;
      end else if (nmi_ack) begin
        nmi_q <= 1'b0;
      end
    end
  end

  assign cpu_nmi  = nmi_q;
  assign cpu_irq  = irq_sync_q[1];
  assign cpu_firq = firq_sync_q[1];

endmodule
`default_nettype wire

// File: tb/tb_jtkcpu_busctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_jtkcpu_busctl: scoreboard bench for jtkcpu_busctl (WAIT=0/TIMEOUT=4   |
// | and WAIT=3/TIMEOUT=255 instances on shared stimulus).  Revision: 1.0     |
// +--------------------------------------------------------------------------+
module tb_jtkcpu_busctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cen, cpu_we, cpu_as, mem_ok, nmi_ack;
  logic        nmi_pin, irq_pin, firq_pin;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout, mem_din;
  logic        cen_alt;
  logic        sel;

  logic [7:0]  d0_cpu_din, d3_cpu_din, d0_mem_dout, d3_mem_dout;
  logic [15:0] d0_mem_addr, d3_mem_addr;
  logic        d0_dtack, d3_dtack, d0_mem_we, d3_mem_we, d0_mem_cs, d3_mem_cs;
  logic        d0_nmi, d3_nmi, d0_irq, d3_irq, d0_firq, d3_firq, d0_err, d3_err;

  jtkcpu_busctl #(.WAIT(0), .TIMEOUT(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_we(cpu_we), .cpu_as(cpu_as), .cpu_din(d0_cpu_din), .cpu_dtack(d0_dtack),
    .mem_addr(d0_mem_addr), .mem_dout(d0_mem_dout), .mem_we(d0_mem_we), .mem_cs(d0_mem_cs),
    .mem_din(mem_din), .mem_ok(mem_ok), .nmi_pin(nmi_pin), .irq_pin(irq_pin),
    .firq_pin(firq_pin), .cpu_nmi(d0_nmi), .cpu_irq(d0_irq), .cpu_firq(d0_firq),
    .nmi_ack(nmi_ack), .bus_err(d0_err)
  );

  jtkcpu_busctl #(.WAIT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_we(cpu_we), .cpu_as(cpu_as), .cpu_din(d3_cpu_din), .cpu_dtack(d3_dtack),
    .mem_addr(d3_mem_addr), .mem_dout(d3_mem_dout), .mem_we(d3_mem_we), .mem_cs(d3_mem_cs),
    .mem_din(mem_din), .mem_ok(mem_ok), .nmi_pin(nmi_pin), .irq_pin(irq_pin),
    .firq_pin(firq_pin), .cpu_nmi(d3_nmi), .cpu_irq(d3_irq), .cpu_firq(d3_firq),
    .nmi_ack(nmi_ack), .bus_err(d3_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_cs();
    return sel ? d3_mem_cs : d0_mem_cs;
  endfunction
  function automatic logic cur_dtack();
    return sel ? d3_dtack : d0_dtack;
  endfunction
  function automatic logic cur_err();
    return sel ? d3_err : d0_err;
  endfunction
  function automatic logic [7:0] cur_din();
    return sel ? d3_cpu_din : d0_cpu_din;
  endfunction

  typedef struct {
    logic [7:0] din;
    int         err;
  } exp_t;

  typedef struct {
    int          wait_cen;
    int          acc_cen;
    int          cs_clks;
    int          lat;
    int          drop;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        we;
  } res_t;

  exp_t sb_q[$];
  int   err_seen;
  logic dt_prev;

  // Scoreboard: every rising dtack pops one expected result and checks
  // returned data plus the number of bus_err clocks seen since the last one.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      err_seen = 0;
      dt_prev  = 1'b0;
    end else begin
      if (cur_err()) err_seen++;
      if (cur_dtack() && !dt_prev) begin
        if (sb_q.size() == 0) begin
          chk("sb_spurious_dtack", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          chk("sb_din", 32'(cur_din()), 32'(e.din));
          chk("sb_bus_err_clks", 32'(err_seen), 32'(e.err));
        end
        err_seen = 0;
      end
      dt_prev = cur_dtack();
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      cen = cen_alt ? ~cen : 1'b1;
    end
  endtask

  task automatic do_reset(input logic s, input logic alt);
    rst_n   = 1'b0;
    cpu_as  = 1'b0;
    cpu_we  = 1'b0;
    mem_ok  = 1'b0;
    nmi_ack = 1'b0;
    sel     = s;
    cen_alt = alt;
    tick(2);
    rst_n = 1'b1;
    tick(3);
  endtask

  // ok_at: 0 = mem_ok high throughout, -1 = never, n>0 = raised after n cen ticks in ACCESS
  task automatic run_access(input logic [15:0] a, input logic we, input logic [7:0] d,
                            input int ok_at, input exp_t e, input int hold, output res_t r);
    logic pre_cen, pre_cs, seen_latch, seen_cs, latched_before, done;
    r = '{default: 0};
    seen_latch = 1'b0;
    seen_cs    = 1'b0;
    done       = 1'b0;
    cpu_addr   = a;
    cpu_we     = we;
    cpu_dout   = d;
    mem_ok     = (ok_at == 0);
    cpu_as     = 1'b1;
    sb_q.push_back(e);
    for (int i = 0; i < 400 && !done; i++) begin
      pre_cen        = cen;
      pre_cs         = cur_cs();
      latched_before = seen_latch;
      tick();
      if (pre_cs && pre_cen) r.acc_cen++;
      if (latched_before) r.lat++;
      if (!seen_latch) begin
        if (pre_cen) seen_latch = 1'b1;
      end else if (!seen_cs && pre_cen) begin
        r.wait_cen++;
      end
      if (cur_cs() && !seen_cs) begin
        seen_cs = 1'b1;
        r.addr  = sel ? d3_mem_addr : d0_mem_addr;
        r.dout  = sel ? d3_mem_dout : d0_mem_dout;
        r.we    = sel ? d3_mem_we   : d0_mem_we;
      end
      if (cur_cs()) r.cs_clks++;
      if (ok_at > 0 && r.acc_cen >= ok_at) mem_ok = 1'b1;
      if (cur_dtack()) done = 1'b1;
    end
    chk("dtack_within_budget", 32'(done), 32'd1);
    if (hold > 0) begin
      tick(hold);
      chk("dtack_held_while_as", 32'(cur_dtack()), 32'd1);
    end
    cpu_as = 1'b0;
    while (cur_dtack() && r.drop < 8) begin
      tick();
      r.drop++;
    end
    chk("dtack_dropped", 32'(cur_dtack()), 32'd0);
    mem_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    res_t r;
    rst_n = 1'b1; cen = 1'b1; cen_alt = 1'b0; sel = 1'b0;
    cpu_addr = '0; cpu_dout = '0; cpu_we = 1'b0; cpu_as = 1'b0;
    mem_din = '0; mem_ok = 1'b0; nmi_ack = 1'b0;
    nmi_pin = 1'b1; irq_pin = 1'b1; firq_pin = 1'b0;

    // Reset values, then a pin already high at release must not raise cpu_nmi
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cpu_din", 32'(d0_cpu_din), 32'hFF);
    chk("rst_mem_bus", {d0_mem_addr, d0_mem_dout, 5'd0, d0_mem_we, d0_mem_cs, d0_dtack}, 32'd0);
    chk("rst_flags", {d0_err, d0_nmi, d0_irq, d0_firq, d3_err, d3_nmi, d3_irq, d3_firq}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("nmi_high_at_release", 32'(d0_nmi), 32'd0);
    chk("irq_level_follows", 32'(d0_irq), 32'd1);
    nmi_pin = 1'b0; irq_pin = 1'b0;

    // WAIT=0 read, mem_ok already high, cen every clk
    do_reset(1'b0, 1'b0);
    mem_din = 8'hA5;
    run_access(16'h1234, 1'b0, 8'h00, 0, '{din: 8'hA5, err: 0}, 3, r);
    chk("rd_wait_cen", 32'(r.wait_cen), 32'd0);
    chk("rd_cs_clks", 32'(r.cs_clks), 32'd1);
    chk("rd_latency", 32'(r.lat), 32'd1);
    chk("rd_addr", 32'(r.addr), 32'h1234);
    chk("rd_we", 32'(r.we), 32'd0);
    chk("rd_drop_clks", 32'(r.drop), 32'd1);

    // TIMEOUT=4, mem_ok never arrives
    mem_din = 8'h00;
    run_access(16'h2000, 1'b0, 8'h00, -1, '{din: 8'hFF, err: 1}, 0, r);
    chk("to_acc_cen", 32'(r.acc_cen), 32'd4);
    chk("to_cs_clks", 32'(r.cs_clks), 32'd4);

    // mem_ok coincides with the 4th cen tick: data wins, no bus_err
    mem_din = 8'h96;
    run_access(16'h2001, 1'b0, 8'h00, 3, '{din: 8'h96, err: 0}, 0, r);
    chk("race_acc_cen", 32'(r.acc_cen), 32'd4);

    // WAIT=3, cen every other clk: read then write
    do_reset(1'b1, 1'b1);
    mem_din = 8'hC3;
    run_access(16'h0042, 1'b0, 8'h00, 0, '{din: 8'hC3, err: 0}, 1, r);
    chk("w3_rd_wait_cen", 32'(r.wait_cen), 32'd3);
    mem_din = 8'h77;
    run_access(16'hFF00, 1'b1, 8'h5A, 0, '{din: 8'hC3, err: 0}, 0, r);
    chk("w3_wr_wait_cen", 32'(r.wait_cen), 32'd3);
    chk("w3_wr_bus", {r.addr, r.dout, 7'd0, r.we}, {16'hFF00, 8'h5A, 8'h01});
    chk("w3_wr_cs_clks", 32'(r.cs_clks), 32'd1);
    tick(3);
    chk("w3_addr_holds", {d3_mem_addr, d3_mem_dout, 7'd0, d3_mem_we}, {16'hFF00, 8'h5A, 8'h01});

    // Interrupts with cen toggling: latency must be cen-independent
    nmi_pin = 1'b1;
    tick(2);
    chk("nmi_before_3clk", 32'(d3_nmi), 32'd0);
    tick(1);
    chk("nmi_at_3clk", 32'(d3_nmi), 32'd1);
    nmi_pin = 1'b0;
    tick(4);
    chk("nmi_held", 32'(d3_nmi), 32'd1);
    nmi_pin = 1'b1;
    tick(2);
    nmi_ack = 1'b1;
    tick(1);
    nmi_ack = 1'b0;
    chk("nmi_edge_beats_ack", 32'(d3_nmi), 32'd1);
    nmi_ack = 1'b1;
    tick(1);
    nmi_ack = 1'b0;
    chk("nmi_ack_clears", 32'(d3_nmi), 32'd0);
    tick(4);
    chk("nmi_level_no_retrigger", 32'(d3_nmi), 32'd0);
    nmi_pin = 1'b0;
    irq_pin = 1'b1;
    tick(1);
    chk("irq_after_1clk", 32'(d3_irq), 32'd0);
    tick(1);
    chk("irq_after_2clk", 32'(d3_irq), 32'd1);
    firq_pin = 1'b1;
    tick(3);
    firq_pin = 1'b0;
    tick(1);
    chk("firq_fall_1clk", 32'(d3_firq), 32'd1);
    tick(1);
    chk("firq_fall_2clk", 32'(d3_firq), 32'd0);
    irq_pin = 1'b0;

    // Reset asserted in ACCESS aborts immediately, then a clean cycle follows
    do_reset(1'b0, 1'b0);
    cpu_addr = 16'hDEAD; cpu_dout = 8'h11; cpu_we = 1'b1; mem_ok = 1'b0; cpu_as = 1'b1;
    tick(1);
    chk("abort_in_access", 32'(d0_mem_cs), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_mem_bus", {d0_mem_addr, d0_mem_dout, 5'd0, d0_mem_we, d0_mem_cs, d0_dtack}, 32'd0);
    chk("abort_din_err", {d0_cpu_din, 7'd0, d0_err}, 16'hFF00);
    cpu_as = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    mem_din = 8'h3C;
    run_access(16'h0BEE, 1'b0, 8'h00, 0, '{din: 8'h3C, err: 0}, 0, r);
    chk("clean_cs_clks", 32'(r.cs_clks), 32'd1);
    chk("clean_addr", 32'(r.addr), 32'h0BEE);

    tick(2);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtkcpu_busctl.md
JTKCPU_BUSCTL -- requirements
Module: jtkcpu_busctl

Interface
REQ-001 Parameter WAIT, default 0: extra cen ticks inserted before each memory access (range 0-15).
REQ-002 Parameter TIMEOUT, default 255: cen ticks allowed for mem_ok before aborting the access (range 1-255).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cen  input  1  CPU clock enable; qualifies the FSM and counters where stated.
REQ-007 cpu_addr  input  16  CPU address.
REQ-008 cpu_dout  input  8  CPU write data.
REQ-009 cpu_we  input  1  CPU write enable.
REQ-010 cpu_as  input  1  CPU address strobe; a high level requests a bus cycle.
REQ-011 cpu_din  output  8  read data returned to the CPU.
REQ-012 cpu_dtack  output  1  data acknowledge to the CPU.
REQ-013 mem_addr  output  16  latched memory address.
REQ-014 mem_dout  output  8  latched write data.
REQ-015 mem_we  output  1  latched write enable.
REQ-016 mem_cs  output  1  memory chip select; high only in ACCESS.
REQ-017 mem_din  input  8  memory read data.
REQ-018 mem_ok  input  1  memory ready, sampled every clk.
REQ-019 nmi_pin, irq_pin, firq_pin  input  1 each  asynchronous active-high interrupt pins.
REQ-020 cpu_nmi, cpu_irq, cpu_firq  output  1 each  interrupt requests to the CPU.
REQ-021 nmi_ack  input  1  CPU acknowledge that clears the latched NMI.
REQ-022 bus_err  output  1  one-clk pulse on an access timeout.

Function
REQ-023 The FSM SHALL have four states: IDLE, WAIT, ACCESS, DONE.
REQ-024 IDLE: on cen & cpu_as, latch cpu_addr/cpu_dout/cpu_we into mem_addr/mem_dout/mem_we, clear the timeout counter, go to WAIT (wait counter=WAIT) if WAIT>0, else go to ACCESS.
REQ-025 WAIT: decrement the wait counter on each cen; when it reaches 0 (same edge), go to ACCESS.
REQ-026 ACCESS: mem_cs=1; on mem_ok at any clk, capture mem_din into cpu_din for reads (leave cpu_din unchanged for writes), then go to DONE on the next edge.
REQ-027 ACCESS timeout: increment the counter on each cen; when it reaches TIMEOUT without mem_ok, set cpu_din=8'hFF, pulse bus_err for one clk, go to DONE.
REQ-028 If mem_ok and the timeout occur on the same edge, mem_ok SHALL win and bus_err SHALL stay low.
REQ-029 DONE: cpu_dtack=1; on cen with cpu_as low, go to IDLE and drop cpu_dtack on the same edge.
REQ-030 If cpu_as drops during WAIT or ACCESS, the access SHALL complete normally; DONE then exits on the next cen.
REQ-031 Latched mem_addr/mem_dout/mem_we SHALL hold from the latch until the next IDLE latch.
REQ-032 Read latency with WAIT=0 and mem_ok already high: the access is latched at IDLE, ACCESS lasts one clk, and cpu_dtack is high on the following edge.
REQ-033 Each interrupt pin SHALL pass through a 2-flop synchronizer; cpu_irq and cpu_firq equal the synchronized levels, 2 clk after the pin.
REQ-034 cpu_nmi SHALL be set on a synchronized rising edge of nmi_pin and held until nmi_ack; a level held high SHALL not re-trigger.
REQ-035 If a new NMI edge and nmi_ack occur on the same edge, cpu_nmi SHALL remain set.
REQ-036 Interrupt logic SHALL not depend on cen.

Reset
REQ-037 rst_n low SHALL immediately force state=IDLE, mem_cs=0, mem_we=0, mem_addr=0, mem_dout=0, cpu_din=8'hFF, cpu_dtack=0, bus_err=0, cpu_nmi=cpu_irq=cpu_firq=0, synchronizers=0, counters=0.
REQ-038 Reset asserted mid-access SHALL abort the access with no dtack and no bus_err.
REQ-039 A pin already high at reset release SHALL not set cpu_nmi.

Verification
REQ-040 WAIT=0, cen=1 every clk, read 16'h1234, mem_ok high, mem_din=8'hA5 -> mem_cs high for 1 clk, cpu_din=8'hA5, dtack held until cpu_as drops.
REQ-041 WAIT=3, cen every other clk, write 8'h5A to 16'hFF00 -> mem_cs rises after 3 cen ticks, mem_we=1, mem_dout=8'h5A, cpu_din unchanged.
REQ-042 TIMEOUT=4, mem_ok never asserted -> bus_err one-clk pulse after 4 cen ticks in ACCESS, cpu_din=8'hFF, then dtack.
REQ-043 TIMEOUT=4, mem_ok on the 4th cen tick -> data captured, no bus_err.
REQ-044 nmi_pin pulse, then nmi_ack coinciding with a second edge -> cpu_nmi set 3 clk after the first edge and still 1 after the ack.
REQ-045 rst_n low during ACCESS -> all outputs at reset values immediately; the next cpu_as starts a clean cycle.
